cam_capture_packer: RTL and testbench
=====================================

Name: cam_capture_packer

Overview:
Parametrised successor to the single-byte camera reader in the camera path. It runs on the pixel clock and captures DVP-style frames (vsync/href/din). It packs DIN_W-bit samples into OUT_W-bit words for the stream buffer, and supports continuous, single-shot and stop commands. It also measures line length and frame height, counts frames, and flags overflow on the output handshake.

Parameters:
DIN_W, 8, sample width per pclk; OUT_W must be an integer multiple of DIN_W
OUT_W, 64, packed output word width
CNT_W, 16, width of hlen/vlen/frame counters; all counters saturate at all-ones

Ports:
pclk  in  1  sole clock, rising edge
rst_n  in  1  asynchronous active-low reset
din  in  DIN_W  pixel sample, already synchronised upstream
vsync  in  1  high during vertical blanking; falling edge = frame start, rising edge = frame end
href  in  1  high while din carries valid pixels
cmd_start  in  1  one-cycle pulse: continuous capture
cmd_single  in  1  one-cycle pulse: capture exactly one frame
cmd_stop  in  1  one-cycle pulse: stop after the current frame
dout  out  OUT_W  packed word; first sample in bits [DIN_W-1:0]
dout_valid  out  1  dout holds a word
dout_ready  in  1  consumer accepts when dout_valid && dout_ready
frame_done  out  1  one-cycle pulse at end of each captured frame
hlen  out  CNT_W  href-high cycles of the last completed line
vlen  out  CNT_W  lines in the last completed frame
frame_cnt  out  CNT_W  captured frames since reset
overflow  out  1  sticky: packed word lost
busy  out  1  state != IDLE

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, lane counter 0, internal edge detectors 0.
- FSM states: IDLE, WAIT_VS, ACTIVE.
  - IDLE -> WAIT_VS on cmd_start or cmd_single; the single flag latches on cmd_single.
  - WAIT_VS -> ACTIVE on a vsync falling edge (vsync delayed by 1 cycle internally).
  - ACTIVE -> on vsync rising edge: frame-end processing, then IDLE if the single or stop flag is set, else WAIT_VS.
- Command priority, same cycle: cmd_stop > cmd_single > cmd_start.
  - cmd_stop in WAIT_VS: -> IDLE next cycle.
  - cmd_stop in ACTIVE: sets the stop flag; the frame completes.
  - cmd_stop in IDLE: no effect.
  - cmd_start or cmd_single in ACTIVE/WAIT_VS: updates the single flag only (start clears it, single sets it).
- Packing, in ACTIVE with href=1:
  - din is written to lane lane_cnt of the pack register.
  - lane_cnt wraps at OUT_W/DIN_W.
  - On the last lane the word is complete.
- Output register:
  - A completed word loads into dout with dout_valid=1 on the next cycle (latency 1 from the final sample) if dout_valid=0 or the current word is accepted that cycle.
  - Otherwise the new word is dropped, overflow sets, and the held word is untouched.
  - dout is stable while dout_valid && !dout_ready.
- Frame end (vsync rising in ACTIVE):
  - If lane_cnt>0, the partial word is zero-padded in the upper lanes and flushed through the same output rules (overflow if blocked); lane_cnt returns to 0.
  - frame_done pulses the cycle after the vsync edge is detected.
  - vlen is latched; frame_cnt increments (saturating).
- hlen: counts href-high cycles in ACTIVE and latches on the href falling edge; the line counter increments on the same edge.
- vsync rising edge while href=1: the line is counted and hlen is latched.
- Reset mid-frame discards the partial word and the held word.

Optional Feature:
CAM_CROP_EN:
- When defined, adds ports crop_x0, crop_xlen, crop_y0, crop_ylen (CNT_W each, quasi-static).
- Only samples with column in [x0, x0+xlen) and line in [y0, y0+ylen) are packed.
- hlen and vlen still report the raw geometry.
- When undefined, the ports are absent and every href sample is packed.

Decomposition:
- Shared camera package: FSM state enum (IDLE/WAIT_VS/ACTIVE), LANES = OUT_W/DIN_W, edge-detect helper constants.
- One natural sub-module, cam_word_packer: lane counter, pack register, zero-pad flush, output register and overflow logic.
- The top level holds the FSM, edge detect, geometry counters and crop.

Test Plan:
- DIN_W=8, OUT_W=64, cmd_single, frame of 4 lines x 16 href cycles with din=incrementing byte, dout_ready=1 -> 8 words, first 64'h0706050403020100; hlen=16, vlen=4, frame_cnt=1, frame_done once, then IDLE.
- Line of 12 samples, one line per frame -> second word has the upper 4 bytes zero, flushed at vsync rise; frame_done one cycle after the edge.
- dout_ready=0 for the whole frame of 16 samples -> first word held unchanged, second dropped, overflow=1 and stays 1.
- cmd_start with 3 frames, cmd_stop during frame 2 -> frames 1 and 2 captured, frame_cnt=2, busy=0 after the frame-2 vsync rise.
- cmd_stop and cmd_start in the same cycle from IDLE -> stays IDLE. rst_n low mid-line -> all outputs 0 immediately, no dout_valid after release.
- With CAM_CROP_EN: x0=4, xlen=8, y0=1, ylen=2 on 4x16 frame -> exactly 2 words; hlen=16, vlen=4.

Source files
------------

// File: rtl/cam_capture_packer_pkg.sv
// Shared camera-path definitions: capture FSM states, lane geometry and edge-detect helpers.
package cam_capture_packer_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT_VS = 2'd1,
        ACTIVE  = 2'd2
    } cam_state_t;

    localparam int DEF_DIN_W = 8;
    localparam int DEF_OUT_W = 64;
    localparam int DEF_CNT_W = 16;
    localparam int LANES     = DEF_OUT_W / DEF_DIN_W;

    // Edge-detect delay registers start low, so a high level at reset release reads as a rising edge.
    localparam logic EDGE_RST = 1'b0;

    function automatic int lanes_f(input int out_w, input int din_w);
        return out_w / din_w;
    endfunction

    function automatic logic rise_f(input logic prev, input logic cur);
        return !prev && cur;
    endfunction

    function automatic logic fall_f(input logic prev, input logic cur);
        return prev && !cur;
    endfunction

endpackage

// File: rtl/cam_capture_packer_word_packer.sv
// Lane packer: gathers DIN_W samples into OUT_W words, zero-pad flush, single-entry output register with sticky overflow.
module cam_word_packer
    import cam_capture_packer_pkg::*;
#(
    parameter int DIN_W = 8,
    parameter int OUT_W = 64
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [DIN_W-1:0] i_din,
    input  logic             i_wr,
    input  logic             i_flush,
    input  logic             i_ready,
    output logic [OUT_W-1:0] o_dout,
    output logic             o_valid,
    output logic             o_overflow
);

    localparam int LANES_L = lanes_f(OUT_W, DIN_W);
    localparam int LW      = (LANES_L > 1) ? $clog2(LANES_L) : 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(LANES_L - 1);

    logic [LW-1:0]    r_lane;
    logic [OUT_W-1:0] r_pack;
    logic [OUT_W-1:0] r_dout;
    logic             r_valid;
    logic             r_overflow;
    logic [OUT_W-1:0] w_word;
    logic             w_last;
    logic             w_emit;
    logic             w_can_load;

    // The pack register is cleared after every emit, so unused upper lanes are already zero on a flush.
    always_comb begin
        w_word = r_pack;
        if (i_wr) begin
            w_word[r_lane*DIN_W +: DIN_W] = i_din;
        end
        w_last     = i_wr && (r_lane == LAST_LANE);
        w_emit     = w_last || (i_flush && (i_wr || (r_lane != '0)));
        w_can_load = !r_valid || i_ready;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_lane     <= '0;
            r_pack     <= '0;
            r_dout     <= '0;
            r_valid    <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (i_flush || w_last) begin
                r_lane <= '0;
                r_pack <= '0;
            end else if (i_wr) begin
                r_lane <= r_lane + 1'b1;
                r_pack <= w_word;
            end

            if (w_emit && w_can_load) begin
                r_dout  <= w_word;
                r_valid <= 1'b1;
            end else begin
                if (w_emit) begin
                    r_overflow <= 1'b1;
                end
                if (r_valid && i_ready) begin
                    r_valid <= 1'b0;
                end
            end
        end
    end

    assign o_dout     = r_dout;
    assign o_valid    = r_valid;
    assign o_overflow = r_overflow;

endmodule

// File: rtl/cam_capture_packer.sv
// DVP frame capture with word packing, geometry measurement and start/single/stop control.
// Optional CAM_CROP_EN adds a rectangular crop window on packed samples.
module cam_capture_packer
    import cam_capture_packer_pkg::*;
#(
    parameter int DIN_W = 8,
    parameter int OUT_W = 64,
    parameter int CNT_W = 16
) (
    input  logic             i_pclk,
    input  logic             i_rst_n,
    input  logic [DIN_W-1:0] i_din,
    input  logic             i_vsync,
    input  logic             i_href,
    input  logic             i_cmd_start,
    input  logic             i_cmd_single,
    input  logic             i_cmd_stop,
    output logic [OUT_W-1:0] o_dout,
    output logic             o_dout_valid,
    input  logic             i_dout_ready,
    output logic             o_frame_done,
    output logic [CNT_W-1:0] o_hlen,
    output logic [CNT_W-1:0] o_vlen,
    output logic [CNT_W-1:0] o_frame_cnt,
    output logic             o_overflow,
    output logic             o_busy
`ifdef CAM_CROP_EN
    ,
    input  logic [CNT_W-1:0] i_crop_x0,
    input  logic [CNT_W-1:0] i_crop_xlen,
    input  logic [CNT_W-1:0] i_crop_y0,
    input  logic [CNT_W-1:0] i_crop_ylen
`endif
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    cam_state_t       r_state, w_state_nx;
    logic             r_single, w_single_nx;
    logic             r_stop, w_stop_nx;
    logic             r_vs_d, r_hr_d;
    logic [CNT_W-1:0] r_hcnt, r_vcnt, r_hlen, r_vlen, r_frame_cnt;
    logic             r_frame_done;
    logic             w_vs_rise, w_vs_fall, w_hr_fall;
    logic             w_active, w_frame_start, w_frame_end, w_line_end;
    logic [CNT_W-1:0] w_vcnt_nx;
    logic             w_crop_ok, w_wr;

    assign w_vs_rise     = rise_f(r_vs_d, i_vsync);
    assign w_vs_fall     = fall_f(r_vs_d, i_vsync);
    assign w_hr_fall     = fall_f(r_hr_d, i_href);
    assign w_active      = (r_state == ACTIVE);
    assign w_frame_start = (r_state == WAIT_VS) && w_vs_fall;
    assign w_frame_end   = w_active && w_vs_rise;
    // A line still high when vsync rises is closed by the frame end itself.
    assign w_line_end    = w_active && (w_hr_fall || (w_vs_rise && i_href));
    assign w_vcnt_nx     = w_line_end ? sat_inc(r_vcnt) : r_vcnt;

`ifdef CAM_CROP_EN
    assign w_crop_ok = ({1'b0, r_hcnt} >= {1'b0, i_crop_x0}) &&
                       ({1'b0, r_hcnt} <  ({1'b0, i_crop_x0} + {1'b0, i_crop_xlen})) &&
                       ({1'b0, r_vcnt} >= {1'b0, i_crop_y0}) &&
                       ({1'b0, r_vcnt} <  ({1'b0, i_crop_y0} + {1'b0, i_crop_ylen}));
`else
    assign w_crop_ok = 1'b1;
`endif

    assign w_wr = w_active && i_href && w_crop_ok;

    always_comb begin
        w_state_nx  = r_state;
        w_single_nx = r_single;
        w_stop_nx   = r_stop;
        if (!i_cmd_stop) begin
            if (i_cmd_single) begin
                w_single_nx = 1'b1;
            end else if (i_cmd_start) begin
                w_single_nx = 1'b0;
            end
        end
        case (r_state)
            IDLE: begin
                w_stop_nx = 1'b0;
                if (!i_cmd_stop && (i_cmd_single || i_cmd_start)) begin
                    w_state_nx = WAIT_VS;
                end
            end
            WAIT_VS: begin
                if (i_cmd_stop) begin
                    w_state_nx = IDLE;
                end else if (w_vs_fall) begin
                    w_state_nx = ACTIVE;
                end
            end
            ACTIVE: begin
                if (i_cmd_stop) begin
                    w_stop_nx = 1'b1;
                end
                if (w_vs_rise) begin
                    w_state_nx = (w_single_nx || w_stop_nx) ? IDLE : WAIT_VS;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= IDLE;
            r_single <= 1'b0;
            r_stop   <= 1'b0;
            r_vs_d   <= EDGE_RST;
            r_hr_d   <= EDGE_RST;
        end else begin
            r_state  <= w_state_nx;
            r_single <= w_single_nx;
            r_stop   <= w_stop_nx;
            r_vs_d   <= i_vsync;
            r_hr_d   <= i_href;
        end
    end

    always_ff @(posedge i_pclk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_hcnt       <= '0;
            r_vcnt       <= '0;
            r_hlen       <= '0;
            r_vlen       <= '0;
            r_frame_cnt  <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_frame_end;
            if (w_line_end) begin
                r_hlen <= w_hr_fall ? r_hcnt : sat_inc(r_hcnt);
            end
            if (w_frame_start || w_frame_end) begin
                r_hcnt <= '0;
                r_vcnt <= '0;
            end else if (w_active) begin
                r_vcnt <= w_vcnt_nx;
                if (w_line_end) begin
                    r_hcnt <= '0;
                end else if (i_href) begin
                    r_hcnt <= sat_inc(r_hcnt);
                end
            end
            if (w_frame_end) begin
                r_vlen      <= w_vcnt_nx;
                r_frame_cnt <= sat_inc(r_frame_cnt);
            end
        end
    end

    cam_word_packer #(
        .DIN_W (DIN_W),
        .OUT_W (OUT_W)
    ) u_packer (
        .i_clk      (i_pclk),
        .i_rst_n    (i_rst_n),
        .i_din      (i_din),
        .i_wr       (w_wr),
        .i_flush    (w_frame_end),
        .i_ready    (i_dout_ready),
        .o_dout     (o_dout),
        .o_valid    (o_dout_valid),
        .o_overflow (o_overflow)
    );

    assign o_frame_done = r_frame_done;
    assign o_hlen       = r_hlen;
    assign o_vlen       = r_vlen;
    assign o_frame_cnt  = r_frame_cnt;
    assign o_busy       = (r_state != IDLE);

endmodule

// File: tb/tb_cam_capture_packer.sv
// Directed bench for cam_capture_packer (DIN_W=8, OUT_W=64, CNT_W=16); crop case built when CAM_CROP_EN is defined.
module tb_cam_capture_packer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  din;
    logic        vsync, href;
    logic        cmd_start, cmd_single, cmd_stop;
    logic [63:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic        frame_done;
    logic [15:0] hlen, vlen, frame_cnt;
    logic        overflow, busy;
`ifdef CAM_CROP_EN
    logic [15:0] crop_x0, crop_xlen, crop_y0, crop_ylen;
`endif

    int total = 0;
    int bad   = 0;
    logic [63:0] got[$];
    int fd_cnt = 0;
    logic fd_now, fd_next, dv_now;
    logic [63:0] dout_now;

    always #5 clk = ~clk;

    cam_capture_packer #(.DIN_W(8), .OUT_W(64), .CNT_W(16)) dut (
        .i_pclk       (clk),
        .i_rst_n      (rst_n),
        .i_din        (din),
        .i_vsync      (vsync),
        .i_href       (href),
        .i_cmd_start  (cmd_start),
        .i_cmd_single (cmd_single),
        .i_cmd_stop   (cmd_stop),
        .o_dout       (dout),
        .o_dout_valid (dout_valid),
        .i_dout_ready (dout_ready),
        .o_frame_done (frame_done),
        .o_hlen       (hlen),
        .o_vlen       (vlen),
        .o_frame_cnt  (frame_cnt),
        .o_overflow   (overflow),
        .o_busy       (busy)
`ifdef CAM_CROP_EN
        ,
        .i_crop_x0    (crop_x0),
        .i_crop_xlen  (crop_xlen),
        .i_crop_y0    (crop_y0),
        .i_crop_ylen  (crop_ylen)
`endif
    );

    // Words are recorded at the negedge before the accepting posedge.
    always @(negedge clk) begin
        if (dout_valid && dout_ready) got.push_back(dout);
        if (frame_done) fd_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic pulse(input logic st, input logic sg, input logic sp);
        cmd_start = st; cmd_single = sg; cmd_stop = sp;
        tick();
        cmd_start = 1'b0; cmd_single = 1'b0; cmd_stop = 1'b0;
    endtask

    task automatic clear_mon();
        got.delete();
        fd_cnt = 0;
    endtask

    // One frame: bytes count up from 0; stop_line >= 0 pulses cmd_stop in that line's gap.
    task automatic send_frame(input int lines, input int pix, input int stop_line);
        int b;
        b = 0;
        vsync = 1'b0;
        tick();
        tick();
        for (int l = 0; l < lines; l++) begin
            href = 1'b1;
            for (int p = 0; p < pix; p++) begin
                din = 8'(b);
                b++;
                tick();
            end
            href = 1'b0;
            din  = 8'h00;
            if (l == stop_line) cmd_stop = 1'b1;
            tick();
            cmd_stop = 1'b0;
            tick();
        end
        vsync = 1'b1;
        tick();
        fd_now   = frame_done;
        dv_now   = dout_valid;
        dout_now = dout;
        tick();
        fd_next = frame_done;
        tick();
        tick();
    endtask

    initial begin
        rst_n = 1'b0; din = '0; vsync = 1'b1; href = 1'b0;
        cmd_start = 1'b0; cmd_single = 1'b0; cmd_stop = 1'b0; dout_ready = 1'b1;
`ifdef CAM_CROP_EN
        crop_x0 = 16'd0; crop_xlen = 16'hFFFF; crop_y0 = 16'd0; crop_ylen = 16'hFFFF;
`endif
        tick();
        tick();
        chk("rst_dout", dout, 64'h0);
        chk("rst_valid", 64'(dout_valid), 64'h0);
        chk("rst_fd", 64'(frame_done), 64'h0);
        chk("rst_hlen", 64'(hlen), 64'h0);
        chk("rst_vlen", 64'(vlen), 64'h0);
        chk("rst_fcnt", 64'(frame_cnt), 64'h0);
        chk("rst_ovf", 64'(overflow), 64'h0);
        chk("rst_busy", 64'(busy), 64'h0);
        rst_n = 1'b1;
        tick();
        tick();

        // Single-shot 4x16 frame.
        clear_mon();
        pulse(1'b0, 1'b1, 1'b0);
        chk("t1_busy_armed", 64'(busy), 64'h1);
        send_frame(4, 16, -1);
        chk("t1_words", 64'(got.size()), 64'd8);
        chk("t1_word0", got[0], 64'h0706050403020100);
        chk("t1_word3", got[3], 64'h1F1E1D1C1B1A1918);
        chk("t1_word7", got[7], 64'h3F3E3D3C3B3A3938);
        chk("t1_hlen", 64'(hlen), 64'd16);
        chk("t1_vlen", 64'(vlen), 64'd4);
        chk("t1_fcnt", 64'(frame_cnt), 64'd1);
        chk("t1_fd_cnt", 64'(fd_cnt), 64'd1);
        chk("t1_busy", 64'(busy), 64'h0);
        chk("t1_ovf", 64'(overflow), 64'h0);

        // 12-sample line: partial word flushed at vsync rise.
        clear_mon();
        pulse(1'b0, 1'b1, 1'b0);
        send_frame(1, 12, -1);
        chk("t2_fd_edge", 64'(fd_now), 64'h1);
        chk("t2_dv_edge", 64'(dv_now), 64'h1);
        chk("t2_flush_word", dout_now, 64'h000000000B0A0908);
        chk("t2_fd_after", 64'(fd_next), 64'h0);
        chk("t2_words", 64'(got.size()), 64'd2);
        chk("t2_word0", got[0], 64'h0706050403020100);
        chk("t2_word1", got[1], 64'h000000000B0A0908);
        chk("t2_hlen", 64'(hlen), 64'd12);
        chk("t2_vlen", 64'(vlen), 64'd1);
        chk("t2_fcnt", 64'(frame_cnt), 64'd2);

        // Consumer stalled for the whole frame.
        clear_mon();
        dout_ready = 1'b0;
        pulse(1'b0, 1'b1, 1'b0);
        send_frame(1, 16, -1);
        chk("t3_held_word", dout, 64'h0706050403020100);
        chk("t3_held_valid", 64'(dout_valid), 64'h1);
        chk("t3_ovf", 64'(overflow), 64'h1);
        dout_ready = 1'b1;
        tick();
        chk("t3_drain_valid", 64'(dout_valid), 64'h0);
        chk("t3_drain_words", 64'(got.size()), 64'd1);
        chk("t3_ovf_sticky", 64'(overflow), 64'h1);

        // Continuous capture, stop during frame 2, frame 3 ignored.
        clear_mon();
        pulse(1'b1, 1'b0, 1'b0);
        send_frame(1, 8, -1);
        chk("t4_busy_f1", 64'(busy), 64'h1);
        chk("t4_fcnt_f1", 64'(frame_cnt), 64'd4);
        send_frame(2, 8, 0);
        chk("t4_busy_f2", 64'(busy), 64'h0);
        chk("t4_fcnt_f2", 64'(frame_cnt), 64'd5);
        send_frame(1, 8, -1);
        chk("t4_fcnt_f3", 64'(frame_cnt), 64'd5);
        chk("t4_words", 64'(got.size()), 64'd3);
        chk("t4_fd_cnt", 64'(fd_cnt), 64'd2);

        // Command priorities.
        pulse(1'b1, 1'b0, 1'b1);
        chk("t5_stop_start_idle", 64'(busy), 64'h0);
        pulse(1'b1, 1'b1, 1'b0);
        chk("t5_single_start_busy", 64'(busy), 64'h1);
        send_frame(1, 8, -1);
        chk("t5_single_wins", 64'(busy), 64'h0);
        chk("t5_fcnt", 64'(frame_cnt), 64'd6);
        pulse(1'b1, 1'b0, 1'b0);
        chk("t5_wait_busy", 64'(busy), 64'h1);
        pulse(1'b0, 1'b0, 1'b1);
        chk("t5_stop_wait", 64'(busy), 64'h0);

`ifdef CAM_CROP_EN
        clear_mon();
        crop_x0 = 16'd4; crop_xlen = 16'd8; crop_y0 = 16'd1; crop_ylen = 16'd2;
        pulse(1'b0, 1'b1, 1'b0);
        send_frame(4, 16, -1);
        chk("crop_words", 64'(got.size()), 64'd2);
        chk("crop_word0", got[0], 64'h1B1A191817161514);
        chk("crop_word1", got[1], 64'h2B2A292827262524);
        chk("crop_hlen", 64'(hlen), 64'd16);
        chk("crop_vlen", 64'(vlen), 64'd4);
        crop_x0 = 16'd0; crop_xlen = 16'hFFFF; crop_y0 = 16'd0; crop_ylen = 16'hFFFF;
`endif

        // Asynchronous reset mid-line with a held word.
        clear_mon();
        dout_ready = 1'b0;
        pulse(1'b1, 1'b0, 1'b0);
        vsync = 1'b0;
        tick();
        tick();
        href = 1'b1;
        for (int p = 0; p < 10; p++) begin
            din = 8'(p);
            tick();
        end
        chk("t6_pre_valid", 64'(dout_valid), 64'h1);
        #2 rst_n = 1'b0;
        #1;
        chk("t6_rst_dout", dout, 64'h0);
        chk("t6_rst_valid", 64'(dout_valid), 64'h0);
        chk("t6_rst_ovf", 64'(overflow), 64'h0);
        chk("t6_rst_fcnt", 64'(frame_cnt), 64'h0);
        chk("t6_rst_hlen", 64'(hlen), 64'h0);
        chk("t6_rst_busy", 64'(busy), 64'h0);
        tick();
        rst_n = 1'b1;
        dout_ready = 1'b1;
        for (int p = 0; p < 6; p++) begin
            din = 8'(p + 10);
            tick();
        end
        href = 1'b0;
        tick();
        vsync = 1'b1;
        tick();
        tick();
        tick();
        chk("t6_no_valid", 64'(dout_valid), 64'h0);
        chk("t6_no_words", 64'(got.size()), 64'd0);
        chk("t6_no_fd", 64'(fd_cnt), 64'd0);
        chk("t6_busy", 64'(busy), 64'h0);
        chk("t6_fcnt", 64'(frame_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
